// File: rtl/ext_bus_responder.sv
// ---------------------------------------------------------------------------
// ext_bus_responder
//
// Memory-side responder for the MCU multiplexed external bus. The low address
// byte is demultiplexed from data_bus under ALE and joined with addr_bus as
// the high byte. Code fetches (PSEN low) and data reads (read_en high) are
// served from an internal byte array after READ_LAT clocks; data writes
// (write_en high) are captured once per strobe. A backdoor port preloads the
// array.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   data_bus   multiplexed low address / data, driven only while drive_en=1
//   addr_bus   high address byte
//   ALE        address latch enable, active high
//   PSEN       code-fetch strobe, active low
//   read_en    data-read strobe, active high
//   write_en   data-write strobe, active high
//   load_en    backdoor array write enable
//   load_addr  backdoor address
//   load_data  backdoor data
//   drive_en   registered; high while the responder drives data_bus
//   bus_err    registered one-cycle protocol-error pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no address held; a strobe here is a protocol error
// ADDR    | ALE high, latching address every edge
// LATCHED | address held, waiting for a strobe
// RWAIT   | read accepted, counting down the access latency
// RDRIVE  | driving read data onto data_bus
// HOLD    | access finished or rejected, waiting for strobes to drop
// ---------------------------------------------------------------------------
module ext_bus_responder #(
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [7:0]        data_bus,
    input  logic [7:0]        addr_bus,
    input  logic              ALE,
    input  logic              PSEN,
    input  logic              read_en,
    input  logic              write_en,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              drive_en,
    output logic              bus_err
);

    typedef enum logic [2:0] {IDLE, ADDR, LATCHED, RWAIT, RDRIVE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [7:0]        lo_lat, hi_lat, dout, dout_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              drive_nxt, err_nxt, lat_en, bus_we;
    logic              rd_req, wr_req;
    logic [15:0]       full_addr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        mem [2**ADDR_W];

    assign rd_req    = !PSEN | read_en;
    assign wr_req    = write_en;
    assign full_addr = {hi_lat, lo_lat};
    // Upper address bits beyond ADDR_W are ignored, so the array aliases.
    assign addr      = full_addr[ADDR_W-1:0];
    assign data_bus  = drive_en ? dout : 8'bz;

    generate
        if (ADDR_W < 16) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^full_addr[15:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lo_lat   <= 8'h00;
            hi_lat   <= 8'h00;
            cnt      <= 4'd0;
            dout     <= 8'h00;
            drive_en <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dout     <= dout_nxt;
            drive_en <= drive_nxt;
            bus_err  <= err_nxt;
            if (lat_en) begin
                lo_lat <= data_bus;
                hi_lat <= addr_bus;
            end
        end
    end

    // Bus write is issued after the load so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        if (bus_we)
            mem[addr] <= data_bus;
    end

    always_comb begin
        state_nxt = state;
        lat_en    = 1'b0;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        drive_nxt = drive_en;
        err_nxt   = 1'b0;
        bus_we    = 1'b0;
        case (state)
            IDLE: begin
                if (ALE) begin
                    state_nxt = ADDR;
                    lat_en    = 1'b1;
                end else if (rd_req || wr_req) begin
                    err_nxt = 1'b1;
                end
            end
            ADDR: begin
                if (ALE) lat_en = 1'b1;
                else     state_nxt = LATCHED;
            end
            LATCHED: begin
                if (ALE) begin
                    state_nxt = ADDR;
                    lat_en    = 1'b1;
                end else if (rd_req && wr_req) begin
                    err_nxt   = 1'b1;
                    state_nxt = HOLD;
                end else if (rd_req) begin
                    if (READ_LAT == 0) begin
                        dout_nxt  = mem[addr];
                        drive_nxt = 1'b1;
                        state_nxt = RDRIVE;
                    end else begin
                        cnt_nxt   = 4'(READ_LAT - 1);
                        state_nxt = RWAIT;
                    end
                end else if (wr_req) begin
                    bus_we    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            RWAIT: begin
                if (ALE) begin
                    err_nxt   = 1'b1;
                    lat_en    = 1'b1;
                    state_nxt = ADDR;
                end else if (!rd_req) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    dout_nxt  = mem[addr];
                    drive_nxt = 1'b1;
                    state_nxt = RDRIVE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RDRIVE: begin
                if (ALE) begin
                    drive_nxt = 1'b0;
                    err_nxt   = 1'b1;
                    lat_en    = 1'b1;
                    state_nxt = ADDR;
                end else if (wr_req) begin
                    drive_nxt = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = HOLD;
                end else if (!rd_req) begin
                    drive_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (ALE) begin
                    err_nxt   = 1'b1;
                    lat_en    = 1'b1;
                    state_nxt = ADDR;
                end else if (!rd_req && !wr_req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                drive_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ext_bus_responder.sv
module tb_ext_bus_responder;

    localparam int AW = 12;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    wire  [7:0]    data_bus;
    logic [7:0]    addr_bus;
    logic          ale, psen, read_en, write_en, load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          drive_en, bus_err;
    logic          tb_oe;
    logic [7:0]    tb_drv;

    int            vectors = 0;
    int            miscompares = 0;
    int            err_seen = 0;
    logic [7:0]    exp_q[$];

    assign data_bus = tb_oe ? tb_drv : 8'bz;

    always #5 clk = ~clk;

    always @(negedge clk) if (bus_err === 1'b1) err_seen++;

    ext_bus_responder #(.ADDR_W(AW), .READ_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .data_bus(data_bus), .addr_bus(addr_bus),
        .ALE(ale), .PSEN(psen), .read_en(read_en), .write_en(write_en),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .drive_en(drive_en), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic backdoor(input logic [AW-1:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    // One-cycle ALE with the address, then one quiet edge into LATCHED.
    task automatic latch(input logic [7:0] hi, input logic [7:0] lo);
        ale = 1'b1; addr_bus = hi; tb_drv = lo; tb_oe = 1'b1;
        step();
        ale = 1'b0; tb_oe = 1'b0;
        step();
    endtask

    // Strobe held for nclk edges; drive_en must rise on the (RL+1)th edge
    // counted from the first strobe edge, then drop one edge after release.
    task automatic do_read(input string tag, input bit use_psen, input int nclk,
                           input logic [7:0] exp, input bit release_it);
        bit         seen = 1'b0;
        logic [7:0] want = 8'h00;
        exp_q.push_back(exp);
        if (use_psen) psen = 1'b0; else read_en = 1'b1;
        for (int i = 1; i <= nclk; i++) begin
            step();
            chk({tag, "_drive"}, {31'd0, drive_en}, {31'd0, (i >= RL + 1)});
            if (drive_en === 1'b1) begin
                if (!seen && exp_q.size() > 0) want = exp_q.pop_front();
                seen = 1'b1;
                chk({tag, "_data"}, {24'd0, data_bus}, {24'd0, want});
            end
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (release_it) begin
            psen = 1'b1; read_en = 1'b0;
            step();
            chk({tag, "_release"}, {31'd0, drive_en}, 32'd0);
        end
    endtask

    initial begin
        int e0;
        rst_n = 1'b0; ale = 1'b0; psen = 1'b1; read_en = 1'b0; write_en = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = 8'h00; addr_bus = 8'h00;
        tb_oe = 1'b0; tb_drv = 8'h00;
        #1;
        chk("rst_drive", {31'd0, drive_en}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // code fetch with latency
        backdoor(12'h123, 8'hA5);
        latch(8'h01, 8'h23);
        e0 = err_seen;
        do_read("fetch", 1'b1, 6, 8'hA5, 1'b1);

        // write held 4 clocks: only the first edge may write
        latch(8'h04, 8'h56);
        write_en = 1'b1; tb_oe = 1'b1; tb_drv = 8'h3C;
        step();
        tb_drv = 8'h99;
        step(); step(); step();
        write_en = 1'b0; tb_oe = 1'b0;
        step();
        latch(8'h04, 8'h56);
        do_read("wr_rd", 1'b0, 4, 8'h3C, 1'b1);

        // aliasing of upper address bits
        backdoor(12'hFFF, 8'h77);
        latch(8'h1F, 8'hFF);
        do_read("alias", 1'b0, 3, 8'h77, 1'b1);
        chk("no_err_reads", err_seen - e0, 32'd0);

        // read with no address phase
        e0 = err_seen;
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        chk("idle_rd_err", {31'd0, bus_err}, 32'd1);
        chk("idle_rd_drive", {31'd0, drive_en}, 32'd0);
        step();
        chk("idle_rd_err_end", {31'd0, bus_err}, 32'd0);
        chk("idle_rd_pulses", err_seen - e0, 32'd1);

        // simultaneous read and write
        backdoor(12'h200, 8'h11);
        latch(8'h02, 8'h00);
        e0 = err_seen;
        read_en = 1'b1; write_en = 1'b1; tb_oe = 1'b1; tb_drv = 8'h55;
        step();
        chk("rw_err", {31'd0, bus_err}, 32'd1);
        step();
        chk("rw_drive", {31'd0, drive_en}, 32'd0);
        read_en = 1'b0; write_en = 1'b0; tb_oe = 1'b0;
        step(); step();
        chk("rw_pulses", err_seen - e0, 32'd1);
        latch(8'h02, 8'h00);
        do_read("rw_nowrite", 1'b0, 3, 8'h11, 1'b1);

        // aborted fetch
        latch(8'h01, 8'h23);
        psen = 1'b0;
        step();
        psen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_nodrive", {31'd0, drive_en}, 32'd0);
        end

        // ALE during RDRIVE
        latch(8'h01, 8'h23);
        e0 = err_seen;
        do_read("pre_ale", 1'b1, 3, 8'hA5, 1'b0);
        psen = 1'b1; ale = 1'b1; addr_bus = 8'h04;
        step();
        chk("ale_abort_drive", {31'd0, drive_en}, 32'd0);
        chk("ale_abort_err", {31'd0, bus_err}, 32'd1);
        tb_oe = 1'b1; tb_drv = 8'h56;
        step();
        ale = 1'b0; tb_oe = 1'b0;
        step();
        chk("ale_abort_pulses", err_seen - e0, 32'd1);
        do_read("relatch", 1'b0, 3, 8'h3C, 1'b1);

        // async reset mid-drive keeps array contents
        latch(8'h04, 8'h56);
        do_read("pre_rst", 1'b0, 4, 8'h3C, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_drive", {31'd0, drive_en}, 32'd0);
        read_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        latch(8'h04, 8'h56);
        do_read("post_rst", 1'b0, 3, 8'h3C, 1'b1);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
